mux4: RTL and testbench
=======================

Name: mux4

Overview:
- 4-to-1 multiplexer built as a two-level tree of 2-to-1 mux stages, with a registered output.
- Selects one of four data lanes packed into input vector i, using two select bits j0 and j1.
- Used as a generic datapath selector; lane width is parameterised, default 1 bit.

Parameters:
- WIDTH, 1, width in bits of each of the four data lanes (legal range >= 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  output-register enable; 1 = load new selection, 0 = hold.
- i  input  4*WIDTH  packed data lanes, declared ascending [0:4*WIDTH-1]. Lane k occupies bits i[k*WIDTH : k*WIDTH+WIDTH-1]. Lane 0 sits at the leftmost (most significant) position of a literal, so for WIDTH=1, 4'b1000 means lane0=1.
- j0  input  1  select bit, most significant.
- j1  input  1  select bit, least significant.
- o  output  WIDTH  registered selected lane.

Behaviour:
- Lane index is sel = {j0, j1}:
  - j0=0, j1=0 -> lane 0
  - j0=0, j1=1 -> lane 1
  - j0=1, j1=0 -> lane 2
  - j0=1, j1=1 -> lane 3
- Mux tree:
  - First level: two mux2 stages; one picks lane0/lane1 by j1, the other picks lane2/lane3 by j1.
  - Second level: one mux2 picks between the two results by j0.
  - The mux2 stage is a separate submodule with data inputs a and b, select s and output y; y = s ? b : a.
- Output register, on each rising clk:
  - if rst=1: o <= 0;
  - else if en=1: o <= selected lane;
  - else o holds its value.
- Latency: o reflects i/j0/j1 sampled at the previous rising edge where en=1; exactly 1 cycle.
- Reset value of o: all zeros. rst has priority over en.
- Reset asserted mid-stream clears o on that edge. On the first edge with rst=0 and en=1, o loads the current selection.
- Unselected lanes never affect o. Changing i or select between edges has no effect until the next edge.
- X/Z on unselected lanes must not propagate to o.
- No internal state besides the o register (plus the optional parity register below).

Optional Feature:
- Macro MUX4_PARITY_EN.
- Defined:
  - Adds output port o_par (1 bit), registered alongside o.
  - o_par = XOR-reduction of the selected lane, loaded under the same rst/en rules as o; reset value 0.
- Not defined:
  - Port o_par is absent; no parity logic is generated.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1, rst=1 for 2 cycles with i=4'b1111 -> o=0 throughout reset; after release with en=1, j0=0, j1=0 -> o=1 one cycle later.
- WIDTH=1, en=1; walk a one-hot lane under its matching select. Each lane is checked twice: all-zero lanes give o=0, then the one-hot pattern gives o=1, each one cycle after the change:
  - i=4'b1000 with j0=0, j1=0
  - i=4'b0100 with j0=0, j1=1
  - i=4'b0010 with j0=1, j1=0
  - i=4'b0001 with j0=1, j1=1
- WIDTH=1, i=4'b0111, all four select codes -> o=0, 1, 1, 1 respectively (unselected lanes ignored).
- WIDTH=8, i={8'hA1, 8'hB2, 8'hC3, 8'hD4} (lane0=A1), sel=2 -> o=8'hC3; with MUX4_PARITY_EN, o_par=0 (C3 has 4 ones).
- en=0 after o=8'hC3 loaded; change sel to 3 -> o stays 8'hC3; en=1 -> o=8'hD4 next cycle.
- rst pulsed for 1 cycle while en=1 and o=8'hD4 -> o=0 on that edge; o=8'hD4 again on the following edge.

Source files
------------

// File: rtl/mux4.sv
// rtl/mux4.sv - 4-to-1 mux tree of mux2 stages with registered output; optional parity via MUX4_PARITY_EN

// 2-to-1 selector stage: y = s ? b : a
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// Top: lane 0 is the leftmost slice of i; sel = {j0, j1}
module mux4 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [0:4*WIDTH-1]   i,
    input  logic                 j0,
    input  logic                 j1,
`ifdef MUX4_PARITY_EN
    output logic                 o_par,
`endif
    output logic [WIDTH-1:0]     o
);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane2;
    logic [WIDTH-1:0] lane3;
    logic [WIDTH-1:0] lo_sel;
    logic [WIDTH-1:0] hi_sel;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;

    // Ascending slices keep lane 0 at the most significant end of a literal
    assign lane0 = i[0*WIDTH +: WIDTH];
    assign lane1 = i[1*WIDTH +: WIDTH];
    assign lane2 = i[2*WIDTH +: WIDTH];
    assign lane3 = i[3*WIDTH +: WIDTH];

    mux2 #(.WIDTH(WIDTH)) u_mux_lo (
        .a (lane0),
        .b (lane1),
        .s (j1),
        .y (lo_sel)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_hi (
        .a (lane2),
        .b (lane3),
        .s (j1),
        .y (hi_sel)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_top (
        .a (lo_sel),
        .b (hi_sel),
        .s (j0),
        .y (mux_out)
    );

    // Next output: reset wins over enable, otherwise load or hold
    always_comb begin
        o_d = o_q;
        if (rst) begin
            o_d = '0;
        end else if (en) begin
            o_d = mux_out;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        o_q <= o_d;
    end

    assign o = o_q;

`ifdef MUX4_PARITY_EN
    logic par_d;
    logic par_q;

    // Parity of the selected lane follows the same reset/enable rules as o
    always_comb begin
        par_d = par_q;
        if (rst) begin
            par_d = 1'b0;
        end else if (en) begin
            par_d = ^mux_out;
        end
    end

    // Parity register
    always_ff @(posedge clk) begin
        par_q <= par_d;
    end

    assign o_par = par_q;
`endif

endmodule

// File: tb/tb_mux4.sv
// tb/tb_mux4.sv - self-checking bench for mux4 at WIDTH=1 and WIDTH=8

module tb_mux4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        j0;
    logic        j1;
    logic [0:3]  i1;
    logic [0:31] i8;
    logic        o1;
    logic [7:0]  o8;
`ifdef MUX4_PARITY_EN
    logic        p1;
    logic        p8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic       m_valid = 1'b0;
    logic       e1;
    logic [7:0] e8;
    logic       ep1;
    logic       ep8;

    always #5 clk = ~clk;

    mux4 #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .i   (i1),
        .j0  (j0),
        .j1  (j1),
`ifdef MUX4_PARITY_EN
        .o_par (p1),
`endif
        .o   (o1)
    );

    mux4 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .i   (i8),
        .j0  (j0),
        .j1  (j1),
`ifdef MUX4_PARITY_EN
        .o_par (p8),
`endif
        .o   (o8)
    );

    // Behavioural model: lane k of a 4-lane word is the k-th group counted from the left
    always @(posedge clk) begin
        int sel;
        logic [3:0]  w1;
        logic [31:0] w8;
        sel = 2 * int'(j0) + int'(j1);
        w1  = i1;
        w8  = i8;
        if (rst) begin
            e1  = 1'b0;
            e8  = 8'h00;
            ep1 = 1'b0;
            ep8 = 1'b0;
        end else if (en) begin
            e1  = w1[3 - sel];
            e8  = 8'((w8 >> (8 * (3 - sel))) & 32'hFF);
            ep1 = e1;
            ep8 = ^e8;
        end
        m_valid = 1'b1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_o1", {7'b0, o1}, {7'b0, e1});
            check("model_o8", o8, e8);
`ifdef MUX4_PARITY_EN
            check("model_p1", {7'b0, p1}, {7'b0, ep1});
            check("model_p8", {7'b0, p8}, {7'b0, ep8});
`endif
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] onehot;
        rst = 1'b1;
        en  = 1'b1;
        j0  = 1'b0;
        j1  = 1'b0;
        i1  = 4'b1111;
        i8  = 32'h0;

        // Reset held for two edges
        step;
        check("rst_c1", {7'b0, o1}, 8'h00);
        step;
        check("rst_c2", {7'b0, o1}, 8'h00);
        rst = 1'b0;
        step;
        check("post_rst_load", {7'b0, o1}, 8'h01);

        // One-hot walk, each lane zero then one
        for (int k = 0; k < 4; k++) begin
            {j0, j1} = 2'(k);
            i1 = 4'b0000;
            step;
            check("walk_zero", {7'b0, o1}, 8'h00);
            onehot = 4'b1000 >> k;
            i1 = onehot;
            step;
            check("walk_one", {7'b0, o1}, 8'h01);
        end

        // Unselected lanes ignored
        i1 = 4'b0111;
        {j0, j1} = 2'd0; step; check("sel0_0111", {7'b0, o1}, 8'h00);
        {j0, j1} = 2'd1; step; check("sel1_0111", {7'b0, o1}, 8'h01);
        {j0, j1} = 2'd2; step; check("sel2_0111", {7'b0, o1}, 8'h01);
        {j0, j1} = 2'd3; step; check("sel3_0111", {7'b0, o1}, 8'h01);

        // Unknowns on unselected lanes must not reach o
        i1 = 4'b1xxx;
        {j0, j1} = 2'd0; step; check("x_unsel", {7'b0, o1}, 8'h01);
        i1 = 4'b0000;

        // Wide lanes
        i8 = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        {j0, j1} = 2'd2;
        step;
        check("w8_sel2", o8, 8'hC3);
`ifdef MUX4_PARITY_EN
        check("w8_par_c3", {7'b0, p8}, 8'h00);
`endif
        {j0, j1} = 2'd0; step; check("w8_sel0", o8, 8'hA1);
        {j0, j1} = 2'd1; step; check("w8_sel1", o8, 8'hB2);
        {j0, j1} = 2'd2; step; check("w8_sel2b", o8, 8'hC3);

        // Hold with en low
        en = 1'b0;
        {j0, j1} = 2'd3;
        step;
        check("hold_1", o8, 8'hC3);
        step;
        check("hold_2", o8, 8'hC3);
        en = 1'b1;
        step;
        check("en_load_d4", o8, 8'hD4);
`ifdef MUX4_PARITY_EN
        check("w8_par_d4", {7'b0, p8}, 8'h00);
`endif

        // Reset pulse mid-stream
        rst = 1'b1;
        step;
        check("rst_pulse", o8, 8'h00);
        rst = 1'b0;
        step;
        check("rst_recover", o8, 8'hD4);

        // Reset priority over en with a changing selection
        rst = 1'b1;
        {j0, j1} = 2'd1;
        step;
        check("rst_prio", o8, 8'h00);
        rst = 1'b0;
        step;
        check("after_prio", o8, 8'hB2);

        step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
